// File: rtl/csr_trap_ctrl_if.sv
// Bus bundle between the core and csr_trap_ctrl: CSR access port,
// trap/interrupt/MRET requests and the fetch redirect.
// master = core side, slave = csr_trap_ctrl.
interface csr_trap_ctrl_if;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata;
   logic        csr_addr_invalid;
   logic        csr_wen;
   logic [31:0] csr_wdata;
   logic        illegal_csr;
   logic        instr_retire;
   logic [31:0] pc_in;
   logic        trap_req;
   logic [31:0] trap_cause;
   logic [31:0] trap_val;
   logic        mret_req;
   logic        ext_irq;
   logic        timer_irq;
   logic [1:0]  current_mode;
   logic        busy;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output csr_addr, csr_wen, csr_wdata, illegal_csr, instr_retire, pc_in,
             trap_req, trap_cause, trap_val, mret_req, ext_irq, timer_irq,
      input  csr_rdata, csr_addr_invalid, current_mode, busy, redirect_valid, redirect_pc
   );

   modport slave (
      input  csr_addr, csr_wen, csr_wdata, illegal_csr, instr_retire, pc_in,
             trap_req, trap_cause, trap_val, mret_req, ext_irq, timer_irq,
      output csr_rdata, csr_addr_invalid, current_mode, busy, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap/MRET sequencer.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   csr_trap_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_TRAP_SAVE  = 2'd1,
      ST_TRAP_REDIR = 2'd2,
      ST_MRET_EXEC  = 2'd3
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [1:0]  mode_r;
   logic        st_mie_r, st_mpie_r;
   logic [1:0]  st_mpp_r;
   logic        ie_mtie_r, ie_meie_r;
   logic [31:0] mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
   logic [31:0] lat_cause_r, lat_pc_r, lat_val_r;
   logic        busy_r, redirect_valid_r;
   logic [31:0] redirect_pc_r;
   logic [31:0] rdata_s, cause_s, val_s;
   logic        invalid_s;

   // MPP only holds M (11) or U (00); any other encoding collapses to U.
   function automatic logic [1:0] legal_mpp(input logic [1:0] v);
      return (v == 2'b11) ? 2'b11 : 2'b00;
   endfunction

   // Vectored mode offsets interrupts by 4*cause; exceptions always use the base.
   function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
      logic [31:0] base;
      base = {tvec[31:2], 2'b00};
      if (tvec[0] && cause[31]) begin
         return base + {25'd0, cause[4:0], 2'b00};
      end else begin
         return base;
      end
   endfunction

   wire in_run_s     = (state_r == ST_RUN);
   wire irq_ext_s    = st_mie_r && ie_meie_r && bus.ext_irq;
   wire irq_tmr_s    = st_mie_r && ie_mtie_r && bus.timer_irq;
   wire irq_take_s   = in_run_s && (irq_ext_s || irq_tmr_s);
   wire mret_legal_s = bus.mret_req && (mode_r == 2'b11);
   wire take_trap_s  = in_run_s && (bus.trap_req || irq_take_s || (bus.mret_req && !mret_legal_s));
   wire take_mret_s  = in_run_s && !bus.trap_req && !irq_take_s && mret_legal_s;
   wire csr_we_s     = in_run_s && bus.csr_wen && !bus.illegal_csr && !bus.trap_req
                       && !irq_take_s && !bus.mret_req;

   // Trap cause/value selection by priority: exception, external, timer, illegal MRET
   always_comb begin
      cause_s = 32'd2;
      val_s   = 32'd0;
      if (bus.trap_req) begin
         cause_s = bus.trap_cause;
         val_s   = bus.trap_val;
      end else if (irq_ext_s) begin
         cause_s = 32'h8000_000B;
      end else if (irq_tmr_s) begin
         cause_s = 32'h8000_0007;
      end else begin
         cause_s = 32'd2;
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_RUN;
      else     state_r <= state_nxt_s;
   end

   // Sequencer next-state: trap takes two busy cycles, MRET one
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (take_trap_s)      state_nxt_s = ST_TRAP_SAVE;
            else if (take_mret_s) state_nxt_s = ST_MRET_EXEC;
            else                  state_nxt_s = ST_RUN;
         end
         ST_TRAP_SAVE:  state_nxt_s = ST_TRAP_REDIR;
         ST_TRAP_REDIR: state_nxt_s = ST_RUN;
         ST_MRET_EXEC:  state_nxt_s = ST_RUN;
         default:       state_nxt_s = ST_RUN;
      endcase
   end

   // Architectural CSR state: trap latch, trap save, MRET restore, software writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r      <= 2'b11;
         st_mie_r    <= 1'b0;
         st_mpie_r   <= 1'b0;
         st_mpp_r    <= 2'b00;
         ie_mtie_r   <= 1'b0;
         ie_meie_r   <= 1'b0;
         mtvec_r     <= MTVEC_RESET;
         mscratch_r  <= 32'd0;
         mepc_r      <= 32'd0;
         mcause_r    <= 32'd0;
         mtval_r     <= 32'd0;
         lat_cause_r <= 32'd0;
         lat_pc_r    <= 32'd0;
         lat_val_r   <= 32'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (take_trap_s) begin
                  lat_cause_r <= cause_s;
                  lat_pc_r    <= bus.pc_in;
                  lat_val_r   <= val_s;
               end else if (csr_we_s) begin
                  case (bus.csr_addr)
                     12'h300: begin
                        st_mie_r  <= bus.csr_wdata[3];
                        st_mpie_r <= bus.csr_wdata[7];
                        st_mpp_r  <= legal_mpp(bus.csr_wdata[12:11]);
                     end
                     12'h304: begin
                        ie_mtie_r <= bus.csr_wdata[7];
                        ie_meie_r <= bus.csr_wdata[11];
                     end
                     12'h305: mtvec_r    <= {bus.csr_wdata[31:2], 1'b0, bus.csr_wdata[0]};
                     12'h340: mscratch_r <= bus.csr_wdata;
                     12'h341: mepc_r     <= {bus.csr_wdata[31:2], 2'b00};
                     12'h342: mcause_r   <= bus.csr_wdata;
                     12'h343: mtval_r    <= bus.csr_wdata;
                     default: ;
                  endcase
               end
            end
            ST_TRAP_SAVE: begin
               mepc_r    <= {lat_pc_r[31:2], 2'b00};
               mcause_r  <= lat_cause_r;
               mtval_r   <= lat_val_r;
               st_mpie_r <= st_mie_r;
               st_mie_r  <= 1'b0;
               st_mpp_r  <= mode_r;
               mode_r    <= 2'b11;
            end
            ST_MRET_EXEC: begin
               mode_r    <= st_mpp_r;
               st_mie_r  <= st_mpie_r;
               st_mpie_r <= 1'b1;
               st_mpp_r  <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   // Registered stall and fetch-redirect outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r           <= 1'b0;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'd0;
      end else begin
         busy_r           <= (state_nxt_s != ST_RUN);
         redirect_valid_r <= (state_r == ST_TRAP_SAVE) || (state_r == ST_MRET_EXEC);
         if (state_r == ST_TRAP_SAVE)      redirect_pc_r <= trap_target(mtvec_r, lat_cause_r);
         else if (state_r == ST_MRET_EXEC) redirect_pc_r <= mepc_r;
         else                              redirect_pc_r <= redirect_pc_r;
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_r, minstret_r;

   // Cycle and retire counters; a write to either half replaces that cycle's increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcycle_r   <= 64'd0;
         minstret_r <= 64'd0;
      end else begin
         if (csr_we_s && (bus.csr_addr == 12'hB00))      mcycle_r <= {mcycle_r[63:32], bus.csr_wdata};
         else if (csr_we_s && (bus.csr_addr == 12'hB80)) mcycle_r <= {bus.csr_wdata, mcycle_r[31:0]};
         else                                            mcycle_r <= mcycle_r + 64'd1;
         if (csr_we_s && (bus.csr_addr == 12'hB02))      minstret_r <= {minstret_r[63:32], bus.csr_wdata};
         else if (csr_we_s && (bus.csr_addr == 12'hB82)) minstret_r <= {bus.csr_wdata, minstret_r[31:0]};
         else if (bus.instr_retire)                      minstret_r <= minstret_r + 64'd1;
         else                                            minstret_r <= minstret_r;
      end
   end
`else
   wire unused_retire_s = bus.instr_retire;
`endif

   // Combinational CSR read mux
   always_comb begin
      rdata_s   = 32'd0;
      invalid_s = 1'b0;
      case (bus.csr_addr)
         12'h300: rdata_s = {19'd0, st_mpp_r, 3'd0, st_mpie_r, 3'd0, st_mie_r, 3'd0};
         12'h304: rdata_s = {20'd0, ie_meie_r, 3'd0, ie_mtie_r, 7'd0};
         12'h305: rdata_s = mtvec_r;
         12'h340: rdata_s = mscratch_r;
         12'h341: rdata_s = mepc_r;
         12'h342: rdata_s = mcause_r;
         12'h343: rdata_s = mtval_r;
         12'h344: rdata_s = {20'd0, bus.ext_irq, 3'd0, bus.timer_irq, 7'd0};
         12'hF14: rdata_s = HART_ID;
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hC00: rdata_s = mcycle_r[31:0];
         12'hB80, 12'hC80: rdata_s = mcycle_r[63:32];
         12'hB02, 12'hC02: rdata_s = minstret_r[31:0];
         12'hB82, 12'hC82: rdata_s = minstret_r[63:32];
`endif
         default: begin
            rdata_s   = 32'd0;
            invalid_s = 1'b1;
         end
      endcase
   end

   assign bus.csr_rdata        = rdata_s;
   assign bus.csr_addr_invalid = invalid_s;
   assign bus.current_mode     = mode_r;
   assign bus.busy             = busy_r;
   assign bus.redirect_valid   = redirect_valid_r;
   assign bus.redirect_pc      = redirect_pc_r;
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: an event-timeline model of the
// architectural state is compared with the DUT every cycle, plus directed
// literal checks.
module tb_csr_trap_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   started = 1'b0;
   int   checks = 0;
   int   failures = 0;

   csr_trap_ctrl_if ifc();

   csr_trap_ctrl #(.MTVEC_RESET(32'h0000_0100), .HART_ID(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [1:0]  m_mode;
   logic [63:0] m_mcycle, m_minstret;
   int          k, free_edge, pend_edge, pend_kind;
   logic [31:0] pend_cause, pend_pc, pend_val;
   logic        exp_busy, exp_rv;
   logic [31:0] exp_rpc;
   bit          cyc_wr, ins_wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [32:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return {1'b0, m_mstatus};
         12'h304: return {1'b0, m_mie};
         12'h305: return {1'b0, m_mtvec};
         12'h340: return {1'b0, m_mscratch};
         12'h341: return {1'b0, m_mepc};
         12'h342: return {1'b0, m_mcause};
         12'h343: return {1'b0, m_mtval};
         12'h344: return {1'b0, (ifc.ext_irq ? 32'h0000_0800 : 32'h0) | (ifc.timer_irq ? 32'h0000_0080 : 32'h0)};
         12'hF14: return {1'b0, 32'h0000_0000};
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hC00: return {1'b0, m_mcycle[31:0]};
         12'hB80, 12'hC80: return {1'b0, m_mcycle[63:32]};
         12'hB02, 12'hC02: return {1'b0, m_minstret[31:0]};
         12'hB82, 12'hC82: return {1'b0, m_minstret[63:32]};
`endif
         default: return {1'b1, 32'h0000_0000};
      endcase
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] d);
      logic [31:0] m;
      case (a)
         12'h300: begin
            m = d & 32'h0000_1888;
            if (((m >> 11) & 32'd3) == 32'd1 || ((m >> 11) & 32'd3) == 32'd2) m = m & ~32'h0000_1800;
            m_mstatus = m;
         end
         12'h304: m_mie      = d & 32'h0000_0880;
         12'h305: m_mtvec    = d & ~32'h0000_0002;
         12'h340: m_mscratch = d;
         12'h341: m_mepc     = d & ~32'h0000_0003;
         12'h342: m_mcause   = d;
         12'h343: m_mtval    = d;
`ifdef CSR_COUNTERS_EN
         12'hB00: begin m_mcycle   = (m_mcycle & 64'hFFFF_FFFF_0000_0000) | {32'd0, d};   cyc_wr = 1'b1; end
         12'hB80: begin m_mcycle   = (m_mcycle & 64'h0000_0000_FFFF_FFFF) | {d, 32'd0};   cyc_wr = 1'b1; end
         12'hB02: begin m_minstret = (m_minstret & 64'hFFFF_FFFF_0000_0000) | {32'd0, d}; ins_wr = 1'b1; end
         12'hB82: begin m_minstret = (m_minstret & 64'h0000_0000_FFFF_FFFF) | {d, 32'd0}; ins_wr = 1'b1; end
`endif
         default: ;
      endcase
   endtask

   task automatic start_trap(input logic [31:0] c, input logic [31:0] p, input logic [31:0] v);
      pend_kind = 1; pend_edge = k + 1; free_edge = k + 3;
      pend_cause = c; pend_pc = p; pend_val = v;
   endtask

   // Model: reacts to the inputs sampled at each rising edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mstatus = 32'd0; m_mie = 32'd0; m_mtvec = 32'h0000_0100; m_mscratch = 32'd0;
         m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0; m_mode = 2'b11;
         m_mcycle = 64'd0; m_minstret = 64'd0;
         k = 0; free_edge = 0; pend_kind = 0; pend_edge = 0;
         exp_busy = 1'b0; exp_rv = 1'b0; exp_rpc = 32'd0;
      end else begin
         k = k + 1;
         exp_rv = 1'b0; cyc_wr = 1'b0; ins_wr = 1'b0;
         if (pend_kind != 0 && k == pend_edge) begin
            if (pend_kind == 1) begin
               m_mepc = pend_pc & ~32'h0000_0003;
               m_mcause = pend_cause;
               m_mtval = pend_val;
               m_mstatus = ({30'd0, m_mode} << 11) | ((m_mstatus & 32'h0000_0008) << 4);
               m_mode = 2'b11;
               exp_rpc = m_mtvec & ~32'h0000_0003;
               if (m_mtvec[0] && pend_cause[31]) exp_rpc = exp_rpc + 32'd4 * (pend_cause & 32'd31);
            end else begin
               m_mode = m_mstatus[12:11];
               m_mstatus = 32'h0000_0080 | ((m_mstatus & 32'h0000_0080) >> 4);
               exp_rpc = m_mepc;
            end
            exp_rv = 1'b1;
            pend_kind = 0;
         end else if (k >= free_edge) begin
            if (ifc.trap_req) start_trap(ifc.trap_cause, ifc.pc_in, ifc.trap_val);
            else if (m_mstatus[3] && m_mie[11] && ifc.ext_irq) start_trap(32'h8000_000B, ifc.pc_in, 32'd0);
            else if (m_mstatus[3] && m_mie[7] && ifc.timer_irq) start_trap(32'h8000_0007, ifc.pc_in, 32'd0);
            else if (ifc.mret_req) begin
               if (m_mode == 2'b11) begin
                  pend_kind = 2; pend_edge = k + 1; free_edge = k + 2;
               end else begin
                  start_trap(32'd2, ifc.pc_in, 32'd0);
               end
            end else if (ifc.csr_wen && !ifc.illegal_csr) model_write(ifc.csr_addr, ifc.csr_wdata);
         end
         if (!cyc_wr) m_mcycle = m_mcycle + 64'd1;
         if (!ins_wr && ifc.instr_retire) m_minstret = m_minstret + 64'd1;
         exp_busy = (k + 1 < free_edge);
      end
   end

   // Compare process: DUT vs model on every falling edge out of reset
   always @(negedge clk) begin
      if (started && !rst) begin
         logic [32:0] r;
         r = model_read(ifc.csr_addr);
         check("cyc_busy", {31'd0, ifc.busy}, {31'd0, exp_busy});
         check("cyc_redirect_valid", {31'd0, ifc.redirect_valid}, {31'd0, exp_rv});
         if (exp_rv) check("cyc_redirect_pc", ifc.redirect_pc, exp_rpc);
         check("cyc_mode", {30'd0, ifc.current_mode}, {30'd0, m_mode});
         check("cyc_rdata", ifc.csr_rdata, r[31:0]);
         check("cyc_invalid", {31'd0, ifc.csr_addr_invalid}, {31'd0, r[32]});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      ifc.csr_addr = a; ifc.csr_wdata = d; ifc.csr_wen = 1'b1;
      step();
      ifc.csr_wen = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp, input logic inv);
      logic [32:0] r;
      ifc.csr_addr = a;
      @(negedge clk);
      r = model_read(a);
      check(name, ifc.csr_rdata, exp);
      check({name, "_inv"}, {31'd0, ifc.csr_addr_invalid}, {31'd0, inv});
      check({name, "_model"}, r[31:0], exp);
   endtask

   task automatic wait_redirect(input string name, input logic [31:0] exp_pc, input int exp_busy_cycles);
      int  nbusy = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (ifc.busy) nbusy++;
         if (ifc.redirect_valid) begin
            seen = 1'b1;
            check({name, "_pc"}, ifc.redirect_pc, exp_pc);
         end
      end
      check({name, "_seen"}, {31'd0, seen}, 32'd1);
      check({name, "_busy_cycles"}, nbusy, exp_busy_cycles);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.csr_addr = 12'h000; ifc.csr_wen = 1'b0; ifc.csr_wdata = 32'd0; ifc.illegal_csr = 1'b0;
      ifc.instr_retire = 1'b0; ifc.pc_in = 32'd0; ifc.trap_req = 1'b0; ifc.trap_cause = 32'd0;
      ifc.trap_val = 32'd0; ifc.mret_req = 1'b0; ifc.ext_irq = 1'b0; ifc.timer_irq = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;

      // reset state
      @(negedge clk);
      check("rst_busy", {31'd0, ifc.busy}, 32'd0);
      check("rst_redirect_valid", {31'd0, ifc.redirect_valid}, 32'd0);
      check("rst_redirect_pc", ifc.redirect_pc, 32'd0);
      check("rst_mode", {30'd0, ifc.current_mode}, 32'd3);
      read_chk("rst_mtvec", 12'h305, 32'h0000_0100, 1'b0);
      read_chk("rst_mstatus", 12'h300, 32'h0000_0000, 1'b0);
      read_chk("unmapped", 12'h7C0, 32'h0000_0000, 1'b1);
      read_chk("mhartid", 12'hF14, 32'h0000_0000, 1'b0);

      // mstatus legalisation
      csr_write(12'h300, 32'hFFFF_FFFF);
      read_chk("mstatus_all", 12'h300, 32'h0000_1888, 1'b0);
      csr_write(12'h300, 32'h0000_0800);
      read_chk("mstatus_mpp01", 12'h300, 32'h0000_0000, 1'b0);

      // scratch, illegal write, read-only write
      csr_write(12'h340, 32'h1234_5678);
      ifc.illegal_csr = 1'b1;
      csr_write(12'h340, 32'h0000_0000);
      ifc.illegal_csr = 1'b0;
      read_chk("mscratch_illegal", 12'h340, 32'h1234_5678, 1'b0);
      csr_write(12'hF14, 32'h0000_0005);
      read_chk("mhartid_ro", 12'hF14, 32'h0000_0000, 1'b0);

      // synchronous exception, with a competing write held through the sequence
      ifc.trap_cause = 32'd2; ifc.pc_in = 32'h0000_0206; ifc.trap_val = 32'hDEAD_BEEF;
      ifc.trap_req = 1'b1; ifc.csr_addr = 12'h340; ifc.csr_wdata = 32'h0; ifc.csr_wen = 1'b1;
      step();
      ifc.trap_req = 1'b0;
      wait_redirect("exc", 32'h0000_0100, 2);
      ifc.csr_wen = 1'b0;
      read_chk("exc_mepc", 12'h341, 32'h0000_0204, 1'b0);
      read_chk("exc_mcause", 12'h342, 32'h0000_0002, 1'b0);
      read_chk("exc_mtval", 12'h343, 32'hDEAD_BEEF, 1'b0);
      read_chk("exc_mstatus", 12'h300, 32'h0000_1800, 1'b0);
      read_chk("exc_mscratch", 12'h340, 32'h1234_5678, 1'b0);

      // timer interrupt, vectored
      csr_write(12'h305, 32'h0000_0203);
      read_chk("mtvec_bit1", 12'h305, 32'h0000_0201, 1'b0);
      csr_write(12'h304, 32'h0000_0080);
      csr_write(12'h300, 32'h0000_0008);
      ifc.pc_in = 32'h0000_0300; ifc.timer_irq = 1'b1;
      step();
      ifc.timer_irq = 1'b0;
      wait_redirect("tmr", 32'h0000_021C, 2);
      read_chk("tmr_mcause", 12'h342, 32'h8000_0007, 1'b0);
      read_chk("tmr_mtval", 12'h343, 32'h0000_0000, 1'b0);
      read_chk("tmr_mepc", 12'h341, 32'h0000_0300, 1'b0);

      // external beats timer
      csr_write(12'h304, 32'h0000_0880);
      csr_write(12'h300, 32'h0000_0008);
      ifc.pc_in = 32'h0000_0310; ifc.ext_irq = 1'b1; ifc.timer_irq = 1'b1;
      step();
      ifc.ext_irq = 1'b0; ifc.timer_irq = 1'b0;
      wait_redirect("ext", 32'h0000_022C, 2);
      read_chk("ext_mcause", 12'h342, 32'h8000_000B, 1'b0);

      // legal MRET to U mode
      csr_write(12'h300, 32'h0000_0080);
      csr_write(12'h341, 32'h0000_0403);
      read_chk("mepc_align", 12'h341, 32'h0000_0400, 1'b0);
      ifc.mret_req = 1'b1;
      step();
      ifc.mret_req = 1'b0;
      wait_redirect("mret", 32'h0000_0400, 1);
      check("mret_mode", {30'd0, ifc.current_mode}, 32'd0);
      read_chk("mret_mstatus", 12'h300, 32'h0000_0088, 1'b0);

      // MRET in U mode becomes an exception
      ifc.pc_in = 32'h0000_0500; ifc.mret_req = 1'b1;
      step();
      ifc.mret_req = 1'b0;
      wait_redirect("umret", 32'h0000_0200, 2);
      check("umret_mode", {30'd0, ifc.current_mode}, 32'd3);
      read_chk("umret_mcause", 12'h342, 32'h0000_0002, 1'b0);
      read_chk("umret_mepc", 12'h341, 32'h0000_0500, 1'b0);
      read_chk("umret_mstatus", 12'h300, 32'h0000_0080, 1'b0);
      check("model_mcause_pin", m_mcause, 32'h0000_0002);

      // reset in the middle of a trap sequence
      ifc.trap_cause = 32'd5; ifc.pc_in = 32'h0000_0600; ifc.csr_addr = 12'h305;
      ifc.trap_req = 1'b1;
      step();
      ifc.trap_req = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, ifc.busy}, 32'd0);
      check("midrst_redirect_valid", {31'd0, ifc.redirect_valid}, 32'd0);
      check("midrst_mtvec", ifc.csr_rdata, 32'h0000_0100);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_redirect", {31'd0, ifc.redirect_valid}, 32'd0);
      end

`ifdef CSR_COUNTERS_EN
      csr_write(12'hB00, 32'hFFFF_FFFF);
      step();
      read_chk("mcycle_hi", 12'hB80, 32'h0000_0001, 1'b0);
      read_chk("mcycle_hi_shadow", 12'hC80, 32'h0000_0001, 1'b0);
      csr_write(12'hB02, 32'h0000_0010);
      ifc.instr_retire = 1'b1;
      step();
      step();
      ifc.instr_retire = 1'b0;
      read_chk("minstret", 12'hB02, 32'h0000_0012, 1'b0);
      ifc.illegal_csr = 1'b1;
      csr_write(12'hB02, 32'h0000_0000);
      ifc.illegal_csr = 1'b0;
      read_chk("minstret_illegal", 12'hC02, 32'h0000_0012, 1'b0);
`else
      csr_write(12'hB00, 32'h0000_1234);
      read_chk("mcycle_absent", 12'hB00, 32'h0000_0000, 1'b1);
      read_chk("minstret_absent", 12'hC02, 32'h0000_0000, 1'b1);
`endif

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
